// File: rtl/serial_audio_pkg.sv
// Shared types and constants for the serial audio transmit path.
package serial_audio_pkg;

  // Transmit frame sequencing.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Parity sense selectors for the PARITY_ODD parameter.
  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

  // 50 MHz system clock divided down to 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags and a drop indicator.
// The head word is always presented on head_data so a consumer can take it
// in the same cycle it pops.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            CLOCK_50,
  input  logic                            Reset,
  input  logic                            push,
  input  logic [DATA_WIDTH-1:0]           push_data,
  input  logic                            pop,
  output logic [DATA_WIDTH-1:0]           head_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic                  push_ok;
  logic                  pop_ok;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = mem[rd_ptr];

  // Occupancy after this cycle's push and pop.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Word storage.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: the storage array is deliberately not reset; pointers and count define which entries are valid.
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, flags and the one-cycle drop pulse.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_next;
      full     <= (count_next == CNT_W'(FIFO_DEPTH));
      empty    <= (count_next == '0);
      overflow <= push && !push_ok;
    end
  end

endmodule

// File: rtl/serial_audio_tx.sv
// Buffered asynchronous serial transmitter: words queue in a FIFO and one
// Start_Flag drains the queue as back-to-back frames on Serial_Data.
module serial_audio_tx
  import serial_audio_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = PARITY_MODE_EVEN,
  parameter int STOP_BITS    = 1
) (
  input  logic                            CLOCK_50,
  input  logic                            Reset,
  input  logic                            Load_Data,
  input  logic [DATA_WIDTH-1:0]           Input_Data,
  input  logic                            Start_Flag,
  output logic                            Serial_Data,
  output logic                            Busy,
  output logic                            Full,
  output logic                            Empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Count,
  output logic                            Overflow
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  // Parity accumulator seed: odd parity is even parity inverted.
  localparam logic PARITY_SEED = (PARITY_ODD == PARITY_MODE_EVEN) ? 1'b0 : 1'b1;

  tx_state_t             state;
  tx_state_t             state_next;
  logic [TMR_W-1:0]      bit_timer;
  logic [TMR_W-1:0]      bit_timer_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  parity_acc;
  logic                  parity_next;
  logic                  serial_next;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  tick;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .push      (Load_Data),
    .push_data (Input_Data),
    .pop       (fifo_pop),
    .head_data (head_data),
    .full      (Full),
    .empty     (Empty),
    .count     (Count),
    .overflow  (Overflow)
  );

  // Terminal count of the bit timer: the current bit period ends this cycle.
  assign tick = (bit_timer == TMR_W'(CLKS_PER_BIT - 1));
  assign Busy = (state != IDLE);

  // Next-state, datapath and next line value for the frame sequencer.
  always_comb begin
    state_next     = state;
    bit_timer_next = bit_timer;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift_reg;
    parity_next    = parity_acc;
    fifo_pop       = 1'b0;
    serial_next    = 1'b1;

    if (state != IDLE) bit_timer_next = tick ? '0 : bit_timer + TMR_W'(1);

    case (state)
      IDLE: begin
        // Empty is registered, so a word loaded this same cycle cannot start a frame.
        if (Start_Flag && !Empty) begin
          state_next     = START;
          fifo_pop       = 1'b1;
          shift_next     = head_data;
          parity_next    = PARITY_SEED;
          bit_timer_next = '0;
        end
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next  = shift_reg >> 1;
          parity_next = parity_acc ^ shift_reg[0];
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_next = '0;
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next   = STOP;
          bit_cnt_next = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
            bit_cnt_next = '0;
            // Chain straight into the next queued word with no idle gap.
            if (!Empty) begin
              state_next  = START;
              fifo_pop    = 1'b1;
              shift_next  = head_data;
              parity_next = PARITY_SEED;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level for the state being entered, so Serial_Data can be a plain register.
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[0];
      PARITY:  serial_next = parity_next;
      default: serial_next = 1'b1;
    endcase
  end

  // Sequencer registers and the registered serial line.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state       <= IDLE;
      bit_timer   <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_acc  <= 1'b0;
      Serial_Data <= 1'b1;
    end else begin
      state       <= state_next;
      bit_timer   <= bit_timer_next;
      bit_cnt     <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_acc  <= parity_next;
      Serial_Data <= serial_next;
    end
  end

endmodule

// File: doc/serial_audio_tx.md
# serial_audio_tx

Buffered, parametrised asynchronous serial transmitter; successor to the fixed 8-bit single-word transmitter on GPIO.
- Queues words in an internal FIFO on `Load_Data`; one `Start_Flag` pulse drains the whole queue back-to-back on `Serial_Data`.
- Word width, bit period, parity and stop-bit count are configurable.
- Sits between the button/edge-detect front end (or an audio sample source) and a GPIO pin.

## Interface
- `DATA_WIDTH`, 8: bits per word, 5..16.
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, 4: word capacity. Power of two, ≥ 2.
- `PARITY_EN`, 0: 1 = append a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `CLOCK_50`  in  1  sole clock. Rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Load_Data`  in  1  one-cycle push strobe for `Input_Data`.
- `Input_Data`  in  DATA_WIDTH  word to enqueue.
- `Start_Flag`  in  1  one-cycle request to begin draining the FIFO.
- `Serial_Data`  out  1  serial line. Idle high.
- `Busy`  out  1  a frame is in progress.
- `Full`  out  1  FIFO holds `FIFO_DEPTH` words.
- `Empty`  out  1  FIFO holds 0 words.
- `Count`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- `Overflow`  out  1  one-cycle pulse when a push is dropped.

## Operation
- Reset values: `Serial_Data`=1, `Busy`=0, `Full`=0, `Empty`=1, `Count`=0, `Overflow`=0, FSM=IDLE, FIFO pointers cleared.
- Push rule: `Load_Data` enqueues when not full, or when full and a pop occurs in the same cycle. Otherwise the word is dropped and `Overflow` pulses the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on `Start_Flag` with `Count` ≠ 0. The head word is popped into a shift register in that cycle.
  - `Start_Flag` in IDLE with an empty FIFO is ignored. This holds even if `Load_Data` is asserted in the same cycle.
  - `Start_Flag` outside IDLE is ignored.
  - START → DATA after 1 bit period.
  - DATA shifts LSB first for `DATA_WIDTH` bit periods, then → PARITY if `PARITY_EN`, else → STOP.
  - PARITY outputs XOR of the data bits, inverted when `PARITY_ODD`.
  - STOP holds the line high for `STOP_BITS` bit periods.
  - At the end of STOP: if the FIFO is non-empty, pop and → START with no idle gap. Otherwise → IDLE.
- Bit timer counts 0..`CLKS_PER_BIT`−1 and wraps. A state or bit advances on the terminal count.
- `Busy` is high in every state except IDLE.

## Timing
- `Start_Flag` accepted at cycle N:
  - `Serial_Data` goes low at N+1.
  - `Count` decrements at N+1.
  - `Busy` rises at N+1.
- Frame length F = (1 + `DATA_WIDTH` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles. Each bit is held exactly `CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins in the cycle immediately after the last stop-bit cycle.
- `Busy` falls in the cycle after the final stop bit of the last queued word.
- `Full`, `Empty` and `Count` update the cycle after a push or pop. A simultaneous push and pop leaves `Count` unchanged.
- `Reset` during a frame: next cycle `Serial_Data`=1, FSM=IDLE, FIFO emptied. The partial frame is abandoned.
- `Serial_Data` is driven from a register. No combinational path from any input to any output.

## Structure
- Package `serial_audio_pkg`: FSM state enumeration; parity-mode constants; default `CLKS_PER_BIT` for 50 MHz/115200.
- Sub-module `sync_fifo`: parameters `DATA_WIDTH` and `FIFO_DEPTH`; push/pop/full/empty/count; registered outputs. Reused by the future receive path.
- Top level contains the FSM, bit timer, bit counter, shift register and parity accumulator.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
1. Assert `Reset` for 2 cycles → `Serial_Data`=1, `Busy`=0, `Empty`=1, `Count`=0, `Overflow`=0.
2. Load 8'b10000010, then `Start_Flag` → line 0 for 4 cycles; bits 0,1,0,0,0,0,0,1 at 4 cycles each; stop 1 for 4 cycles; `Busy` high 40 cycles.
3. Load 0x55, 0xA3, 0xFF, then one `Start_Flag` → three contiguous frames, 120 cycles, no idle gap; `Empty`=1 after the third pop.
4. `PARITY_EN`=1 with 0x07 → parity bit 1 (even), 0 (odd). `STOP_BITS`=2 → frame length 48 cycles.
5. `FIFO_DEPTH`=4, five pushes in IDLE → `Full`=1 after the 4th; 5th dropped; `Overflow` one-cycle pulse; `Count`=4. Push coincident with a pop while full → accepted, `Count` stays 4.
6. `Reset` during data bit 3 → next cycle `Serial_Data`=1, `Busy`=0, `Count`=0. A following `Start_Flag` with the FIFO empty → no frame transmitted.
